// File: rtl/scan_tx_pkg.sv
// Shared types and helpers for the scan chain transmitter.
// Optional feature macro used by the slice: SCAN_TX_PARITY_EN.
package scan_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // A length of zero or beyond the register width means a full-width transfer.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/scan_chain_tx_if.sv
// Request/scan-side bundle of the scan chain transmitter.
// master = requester/harness side, slave = transmitter side.
interface scan_chain_tx_if
    import scan_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);

    logic [WIDTH-1:0] DIN;
    logic [CNT_W-1:0] LEN;
    logic             VALID;
    logic             READY;
    logic             SO;
    logic             SE;
    logic             CAPT;
    logic             BUSY;
    logic             DONE;

    modport master (
        output DIN, LEN, VALID,
        input  READY, SO, SE, CAPT, BUSY, DONE
    );

    modport slave (
        input  DIN, LEN, VALID,
        output READY, SO, SE, CAPT, BUSY, DONE
    );

endinterface

// File: rtl/scan_tx_shreg.sv
// Load / shift-right register with zero fill; lsb is the next bit to launch.
module scan_tx_shreg
    import scan_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/scan_chain_tx.sv
// Parallel-to-serial scan launcher: shifts a word LSB first under SE, then strobes CAPT.
// Define SCAN_TX_PARITY_EN to append an odd-parity bit after the data bits.
module scan_chain_tx
    import scan_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    scan_chain_tx_if.slave   bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sr_lsb;
    logic             accept_c;
    logic             shift_c;
`ifdef SCAN_TX_PARITY_EN
    logic             par;
    logic             par_phase;
`endif

    assign accept_c = (state == IDLE) && bus.VALID && bus.READY;
    assign shift_c  = (state == SHIFT) && (cnt > CNT_W'(1));

    // SO takes DIN[0] directly at accept, so the register only holds the remaining bits.
    scan_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .CLK   (CLK),
        .RST   (RST),
        .load  (accept_c),
        .shift (shift_c),
        .din   (bus.DIN >> 1),
        .lsb   (sr_lsb)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.READY <= 1'b0;
            bus.SO    <= 1'b0;
            bus.SE    <= 1'b0;
            bus.CAPT  <= 1'b0;
            bus.BUSY  <= 1'b0;
            bus.DONE  <= 1'b0;
`ifdef SCAN_TX_PARITY_EN
            par       <= 1'b0;
            par_phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.DONE  <= 1'b0;
                    bus.READY <= 1'b1;
                    if (accept_c) begin
                        state     <= SHIFT;
                        cnt       <= CNT_W'(eff_len(32'(bus.LEN), WIDTH));
                        bus.READY <= 1'b0;
                        bus.SE    <= 1'b1;
                        bus.BUSY  <= 1'b1;
                        bus.SO    <= bus.DIN[0];
`ifdef SCAN_TX_PARITY_EN
                        par       <= ~bus.DIN[0];
                        par_phase <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt > CNT_W'(1)) begin
                        cnt    <= cnt - CNT_W'(1);
                        bus.SO <= sr_lsb;
`ifdef SCAN_TX_PARITY_EN
                        par    <= par ^ sr_lsb;
                    end else if (!par_phase) begin
                        par_phase <= 1'b1;
                        bus.SO    <= par;
`endif
                    end else begin
                        state    <= CAPTURE;
                        bus.SE   <= 1'b0;
                        bus.SO   <= 1'b0;
                        bus.CAPT <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state     <= IDLE;
                    bus.CAPT  <= 1'b0;
                    bus.BUSY  <= 1'b0;
                    bus.DONE  <= 1'b1;
                    bus.READY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_tx.sv
// Scoreboard bench for scan_chain_tx: a driver queues expected scan events, a monitor checks them.
module tb_scan_chain_tx;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = $clog2(W + 1);
`ifdef SCAN_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    localparam int K_BIT  = 0;
    localparam int K_CAPT = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int   kind;
        logic val;
        int   cyc;
    } exp_item_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_item_t exp_q[$];

    int  last_acc  = 0;
    int  last_n    = 0;
    bit  last_hold = 1'b0;

    scan_chain_tx_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();

    scan_chain_tx #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_BIT:   return "bit";
            K_CAPT:  return "capt";
            default: return "done";
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, input logic v);
        exp_item_t it;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=%0b required=no event", kname(kind), cyc, v);
        end else begin
            it = exp_q.pop_front();
            if (it.kind != kind || it.cyc != cyc || it.val !== v) begin
                failures++;
                $display("FAIL event_%s actual=(%s cyc %0d val %0b) required=(%s cyc %0d val %0b)",
                         kname(kind), kname(kind), cyc, v, kname(it.kind), it.cyc, it.val);
            end
        end
    endtask

    // Monitor: every observed scan event must match the head of the expectation queue.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.SE) pop_check(K_BIT, bus.SO);
            else        check("so_low_outside_shift", 64'(bus.SO), 64'd0);
            if (bus.CAPT) pop_check(K_CAPT, 1'b1);
            if (bus.DONE) pop_check(K_DONE, 1'b1);
            check("busy", 64'(bus.BUSY), 64'(bus.SE | bus.CAPT));
        end
    end

    // Issue one request; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input int len, input bit hold);
        int n;
        int c;
        int ones;
        int waited;
        bus.DIN   = d;
        bus.LEN   = CNT_W'(len);
        bus.VALID = 1'b1;
        waited = 0;
        @(negedge CLK);
        while (!bus.READY && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!bus.READY) begin
            check("ready_timeout", 64'(bus.READY), 64'd1);
            bus.VALID = 1'b0;
            last_hold = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        c = cyc;
        n = (len == 0 || len > int'(W)) ? int'(W) : len;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{K_BIT, d[i], c + i});
            ones += int'(d[i]);
        end
        if (P == 1) exp_q.push_back('{K_BIT, ((ones % 2) == 0), c + n});
        exp_q.push_back('{K_CAPT, 1'b1, c + n + P});
        exp_q.push_back('{K_DONE, 1'b1, c + n + P + 1});
        if (last_hold) check("b2b_accept_gap", 64'(c - last_acc), 64'(last_n + 2 + P));
        last_acc  = c;
        last_n    = n;
        last_hold = hold;
        if (!hold) bus.VALID = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        int len;
        bit hold;
        int waited;

        bus.DIN   = 16'h1234;
        bus.LEN   = '0;
        bus.VALID = 1'b1;
        RST       = 1'b1;

        // Reset held with VALID high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            mon_en = 1'b1;
            check("rst_ready", 64'(bus.READY), 64'd0);
            check("rst_se",    64'(bus.SE),    64'd0);
            check("rst_capt",  64'(bus.CAPT),  64'd0);
            check("rst_done",  64'(bus.DONE),  64'd0);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("ready_after_rst", 64'(bus.READY), 64'd1);
        check("se_after_rst",    64'(bus.SE),    64'd0);
        bus.VALID = 1'b0;
        @(posedge CLK);
        #1;

        send(16'hA5C3, 16, 1'b0);
        send(16'h3C96, 0, 1'b0);
        send(16'h5AF0, 20, 1'b0);
        send(16'h0001, 1, 1'b0);

        send(16'hFFFF, 4, 1'b1);
        send(16'h0000, 4, 1'b0);

        // Reset in the middle of a shift abandons the transfer.
        send(16'hBEEF, 16, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        check("midrst_se",    64'(bus.SE),    64'd0);
        check("midrst_capt",  64'(bus.CAPT),  64'd0);
        check("midrst_done",  64'(bus.DONE),  64'd0);
        check("midrst_ready", 64'(bus.READY), 64'd0);
        RST = 1'b0;
        send(16'h8421, 7, 1'b0);
`ifdef SCAN_TX_PARITY_EN
        send(16'h0007, 3, 1'b0);
`endif

        for (int k = 0; k < 30; k++) begin
            d    = W'($urandom);
            len  = int'($urandom_range(0, W + 4));
            hold = ($urandom_range(0, 2) == 0);
            send(d, len, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
        bus.VALID = 1'b0;
        last_hold = 1'b0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        repeat (3) @(negedge CLK);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
